// File: rtl/scan_sequencer.sv
// Sequences a 3-to-8 decoder through its eight slots, holding each slot enabled
// for DIV cycles with GAP blanking cycles between slots, in single-sweep or continuous mode.
module scan_sequencer #(
    parameter int DIV = 4,
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       single,
    input  logic       dir,
    output logic [2:0] i,
    output logic       en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic       NO_GAP   = (GAP == 0);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] i_r, i_s;
    logic       en_r, en_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       single_r, single_s;
    logic       dir_r, dir_s;
    logic       last_slot_s;

    // Step to the neighbouring slot; 3-bit arithmetic gives the 7<->0 wrap.
    function automatic logic [2:0] next_index(input logic [2:0] idx, input logic down);
        logic [2:0] res;
        if (down) begin
            res = idx - 3'd1;
        end else begin
            res = idx + 3'd1;
        end
        return res;
    endfunction

    // Next-state and next-output decode; stop always wins over start and completion.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + 8'd1;
        i_s         = i_r;
        en_s        = en_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        single_s    = single_r;
        dir_s       = dir_r;
        last_slot_s = dir_r ? (i_r == 3'd0) : (i_r == 3'd7);

        case (state_r)
            IDLE: begin
                cnt_s  = 8'd0;
                en_s   = 1'b0;
                busy_s = 1'b0;
                if (stop) begin
                    state_s = IDLE;
                end else if (start) begin
                    state_s  = ACTIVE;
                    en_s     = 1'b1;
                    busy_s   = 1'b1;
                    single_s = single;
                    dir_s    = dir;
                    i_s      = dir ? 3'd7 : 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                    en_s    = 1'b0;
                    busy_s  = 1'b0;
                end else if (cnt_r == DIV_LAST) begin
                    cnt_s = 8'd0;
                    if (single_r && last_slot_s) begin
                        state_s = IDLE;
                        en_s    = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else if (NO_GAP) begin
                        state_s = ACTIVE;
                        i_s     = next_index(i_r, dir_r);
                    end else begin
                        state_s = BLANK;
                        en_s    = 1'b0;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            BLANK: begin
                if (stop) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                    busy_s  = 1'b0;
                end else if (cnt_r == GAP_LAST) begin
                    state_s = ACTIVE;
                    cnt_s   = 8'd0;
                    en_s    = 1'b1;
                    i_s     = next_index(i_r, dir_r);
                end else begin
                    state_s = BLANK;
                end
            end
            default: begin
                state_s  = IDLE;
                cnt_s    = 8'd0;
                i_s      = 3'd0;
                en_s     = 1'b0;
                busy_s   = 1'b0;
                single_s = 1'b0;
                dir_s    = 1'b0;
            end
        endcase
    end

    // State, counter, latched mode bits and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            i_r      <= 3'd0;
            en_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            single_r <= 1'b0;
            dir_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            i_r      <= i_s;
            en_r     <= en_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            single_r <= single_s;
            dir_r    <= dir_s;
        end
    end

    assign i    = i_r;
    assign en   = en_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench: three parameterisations share one stimulus stream and are
// compared every cycle against a timing model derived from slot arithmetic.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       single = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] o_i    [3];
    logic       o_en   [3];
    logic       o_busy [3];
    logic       o_done [3];

    int n_checks = 0;
    int n_fail = 0;

    int pdiv [3] = '{4, 1, 2};
    int pgap [3] = '{1, 0, 3};

    logic       m_busy   [3];
    int         m_n      [3];
    logic       m_single [3];
    logic       m_dir    [3];
    logic       m_en     [3];
    logic       m_done   [3];
    logic [2:0] m_i      [3];

    typedef struct {
        logic       start;
        logic       stop;
        logic       single;
        logic       dir;
        logic [2:0] exp_i;
        logic       exp_en;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t tbl [22];

    always #5 clk = ~clk;

    scan_sequencer #(.DIV(4), .GAP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single), .dir(dir),
        .i(o_i[0]), .en(o_en[0]), .busy(o_busy[0]), .done(o_done[0])
    );
    scan_sequencer #(.DIV(1), .GAP(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single), .dir(dir),
        .i(o_i[1]), .en(o_en[1]), .busy(o_busy[1]), .done(o_done[1])
    );
    scan_sequencer #(.DIV(2), .GAP(3)) u_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .single(single), .dir(dir),
        .i(o_i[2]), .en(o_en[2]), .busy(o_busy[2]), .done(o_done[2])
    );

    task automatic check(input string nm, input int k, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, k, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 1'b0; m_n[k] = 0; m_single[k] = 1'b0; m_dir[k] = 1'b0;
            m_en[k] = 1'b0; m_done[k] = 1'b0; m_i[k] = 3'd0;
        end
    endtask

    // Cycle n after start (n=1 is the first enabled cycle) lies in slot (n-1)/P at
    // phase (n-1)%P with P = DIV+GAP; a single sweep ends at n = 7P+DIV+1.
    task automatic model_step(input logic st, input logic sp, input logic sg, input logic dr);
        for (int k = 0; k < 3; k++) begin
            int p;
            int slot;
            int ph;
            p = pdiv[k] + pgap[k];
            m_done[k] = 1'b0;
            if (m_busy[k]) begin
                if (sp) begin
                    m_busy[k] = 1'b0;
                    m_en[k] = 1'b0;
                end else begin
                    m_n[k]++;
                    if (m_single[k] && m_n[k] == 7 * p + pdiv[k] + 1) begin
                        m_busy[k] = 1'b0;
                        m_en[k] = 1'b0;
                        m_done[k] = 1'b1;
                    end else begin
                        slot = (m_n[k] - 1) / p;
                        ph = (m_n[k] - 1) % p;
                        m_en[k] = (ph < pdiv[k]);
                        m_i[k] = m_dir[k] ? 3'(7 - (slot % 8)) : 3'(slot % 8);
                    end
                end
            end else begin
                m_en[k] = 1'b0;
                if (!sp && st) begin
                    m_busy[k] = 1'b1; m_n[k] = 1; m_single[k] = sg; m_dir[k] = dr;
                    m_en[k] = 1'b1; m_i[k] = dr ? 3'd7 : 3'd0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check("model_i", k, int'(o_i[k]), int'(m_i[k]));
            check("model_en", k, int'(o_en[k]), int'(m_en[k]));
            check("model_busy", k, int'(o_busy[k]), int'(m_busy[k]));
            check("model_done", k, int'(o_done[k]), int'(m_done[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step(start, stop, single, dir);
        check_all();
    endtask

    task automatic set_in(input logic st, input logic sp, input logic sg, input logic dr);
        start = st; stop = sp; single = sg; dir = dr;
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic sg, input logic dr,
                                input int ei, input logic een, input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.single = sg; v.dir = dr;
        v.exp_i = 3'(ei); v.exp_en = een; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int en_cnt;
        int done_cyc;
        int busy40;
        int i36;

        // Continuous descending on DIV=1/GAP=0, stop, start+stop, then a single ascending sweep.
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 9; j++) tbl[j] = mk(1'b0, 1'b0, 1'b0, 1'b1, (15 - j) % 8, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        for (int j = 13; j <= 19; j++) tbl[j] = mk(1'b0, 1'b0, 1'b0, 1'b1, j - 12, 1'b1, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b1);
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0);

        model_reset();
        #2;
        check_all();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step();

        for (int r = 0; r < 22; r++) begin
            set_in(tbl[r].start, tbl[r].stop, tbl[r].single, tbl[r].dir);
            step();
            check("tbl_i", r, int'(o_i[1]), int'(tbl[r].exp_i));
            check("tbl_en", r, int'(o_en[1]), int'(tbl[r].exp_en));
            check("tbl_busy", r, int'(o_busy[1]), int'(tbl[r].exp_busy));
            check("tbl_done", r, int'(o_done[1]), int'(tbl[r].exp_done));
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Single ascending sweep on DIV=4/GAP=1, with and without ignored start/dir activity.
        for (int pass = 0; pass < 2; pass++) begin
            en_cnt = 0; done_cyc = -1; busy40 = -1; i36 = -1;
            set_in(1'b1, 1'b0, 1'b1, 1'b0);
            step();
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 1; c <= 41; c++) begin
                if (o_en[0]) en_cnt++;
                if (o_done[0]) done_cyc = c;
                if (c == 40) busy40 = int'(o_busy[0]);
                if (c == 36) i36 = int'(o_i[0]);
                if (pass == 1 && c < 38) begin
                    start = (c % 3 == 0);
                    dir = c[0];
                    single = ~c[1];
                end else begin
                    set_in(1'b0, 1'b0, 1'b0, 1'b0);
                end
                step();
            end
            check("sweep_en_total", pass, en_cnt, 32);
            check("sweep_done_cycle", pass, done_cyc, 40);
            check("sweep_busy_c40", pass, busy40, 0);
            check("sweep_i_c36", pass, i36, 7);
            set_in(1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end

        // Stop in the first blanking cycle, then restart immediately.
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 5; c++) step();
        check("blank_en_c5", 0, int'(o_en[0]), 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("stop_en", 0, int'(o_en[0]), 0);
        check("stop_busy", 0, int'(o_busy[0]), 0);
        check("stop_done", 0, int'(o_done[0]), 0);
        check("stop_i", 0, int'(o_i[0]), 0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("restart_i", 0, int'(o_i[0]), 0);
        check("restart_en", 0, int'(o_en[0]), 1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Stop and start together in the last enabled cycle of slot 7.
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 39; c++) step();
        check("c39_i", 0, int'(o_i[0]), 7);
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("simul_done", 0, int'(o_done[0]), 0);
        check("simul_busy", 0, int'(o_busy[0]), 0);
        check("simul_i", 0, int'(o_i[0]), 7);
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("simul_restart_busy", 0, int'(o_busy[0]), 1);
        check("simul_restart_i", 0, int'(o_i[0]), 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Asynchronous reset between edges during slot 3.
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 17; c++) step();
        check("slot3_i", 0, int'(o_i[0]), 3);
        check("slot3_en", 0, int'(o_en[0]), 1);
        async_reset_pulse();
        check("areset_i", 0, int'(o_i[0]), 0);
        check("areset_en", 0, int'(o_en[0]), 0);
        check("areset_busy", 0, int'(o_busy[0]), 0);
        for (int c = 0; c < 5; c++) step();

        // Randomised traffic, including occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 59) == 0);
            single = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            step();
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4: number of clock cycles each slot is enabled, legal range 1..255.
REQ-002 SHALL have parameter GAP, default 1: number of blanking cycles between slots, legal range 0..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a scan when idle.
REQ-006 SHALL have port stop, input, 1 bit: aborts a scan in progress.
REQ-007 SHALL have port single, input, 1 bit: 1 = one sweep then stop, 0 = continuous; latched at start.
REQ-008 SHALL have port dir, input, 1 bit: 0 = index ascends 0..7, 1 = descends 7..0; latched at start.
REQ-009 SHALL have port i, output, 3 bits: slot index, driving the 3-to-8 one-hot decoder select.
REQ-010 SHALL have port en, output, 1 bit: decoder enable.
REQ-011 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on single-sweep completion.

Function
REQ-013 SHALL implement FSM states IDLE, ACTIVE and BLANK; every output SHALL be registered.
REQ-014 In IDLE, en, busy and done SHALL be 0, and i SHALL hold its last value.
REQ-015 start=1 in IDLE SHALL cause, on the next cycle: ACTIVE, busy=1, en=1, i=0 (dir=0) or i=7 (dir=1), with single and dir latched.
REQ-016 ACTIVE SHALL last exactly DIV cycles with en=1 and i constant, counted by an 8-bit cycle counter cleared on each state entry.
REQ-017 At the last ACTIVE cycle of the final slot (i=7 ascending, i=0 descending) with latched single=1, the FSM SHALL go to IDLE with done=1 for exactly one cycle and busy=0 in that same cycle; i SHALL hold.
REQ-018 Otherwise, at the last ACTIVE cycle, the FSM SHALL go to BLANK if GAP>0, or go directly to ACTIVE with i advanced if GAP=0.
REQ-019 BLANK SHALL last exactly GAP cycles with en=0, busy=1 and i unchanged, then enter ACTIVE with i advanced.
REQ-020 Index advance SHALL be i+1 (ascending) or i-1 (descending), modulo 8: 7->0 ascending and 0->7 descending wrap in continuous mode.
REQ-021 stop=1 in ACTIVE or BLANK SHALL cause IDLE on the next cycle, with en=0, busy=0, no done pulse, and i held.
REQ-022 stop SHALL have priority over start in every state, and over sweep completion in the same cycle (done stays 0).
REQ-023 start while busy SHALL be ignored; single and dir changes while busy SHALL have no effect.
REQ-024 At most one of en-rising and done SHALL occur per cycle; en and done SHALL never be high together.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force IDLE, i=0, en=0, busy=0, done=0, counter=0, latched single=0 and latched dir=0, including mid-scan.
REQ-026 After rst_n deasserts, the block SHALL remain in IDLE until a start is sampled on a rising clk edge.

Verification (DIV=4, GAP=1 unless stated; cycle 0 = start sampled)
REQ-027 Single ascending sweep: start, single=0->1, dir=0 -> slot k has en=1 in cycles 1+5k..4+5k with i=k, en=0 in between; done=1 only in cycle 40; busy=0 from cycle 40; 32 en-high cycles in total.
REQ-028 Continuous descending, GAP=0, DIV=1: start, single=0, dir=1 -> i = 7,6,...,0,7,6 in consecutive cycles, en held at 1, done never asserted.
REQ-029 Stop mid-BLANK: stop in cycle 5 -> cycle 6 has en=0, busy=0, done=0, i=0; a start in cycle 6 restarts with i=0 in cycle 7.
REQ-030 Simultaneous events: stop=1 and start=1 in the last ACTIVE cycle of slot 7 (single=1) -> IDLE, done=0; start held in IDLE -> new scan begins the next cycle.
REQ-031 Async reset: rst_n pulsed low between clock edges during slot 3 -> en, busy and i go to 0 immediately, without a clock edge; no activity until the next start.
REQ-032 Ignored start: start pulses while busy, with dir toggled -> slot timing and direction are unchanged versus REQ-027.
